// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, FSM state type and control bundle for the pipelined MIPS control unit.
package pipe_ctrl_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned EXE_W = 5;
    localparam int unsigned MEM_W = 2;
    localparam int unsigned WB_W  = 2;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LOAD  = 6'b100011;
    localparam logic [OP_W-1:0] OP_STORE = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_JUMP  = 6'b000010;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b100;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_KILL = 1'b1
    } state_t;

    typedef struct packed {
        logic [EXE_W-1:0] exe;
        logic [MEM_W-1:0] mem;
        logic [WB_W-1:0]  wb;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decoder.sv
// Combinational ID-stage decode of opcode/funct into control bundle and instruction class flags.
module ctrl_decoder
    import pipe_ctrl_pkg::*;
#(
    parameter logic [5:0] NOP_OPCODE = 6'b111111
) (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [4:0] exe,
    output logic [1:0] mem,
    output logic [1:0] wb,
    output logic       is_beq,
    output logic       is_bne,
    output logic       is_load,
    output logic       is_jump,
    output logic       illegal
);

    logic [ALU_W-1:0] alu;
    logic             fn_ok;

    always_comb begin
        alu   = ALU_ADD;
        fn_ok = 1'b1;
        case (funct)
            FN_ADD:  alu = ALU_ADD;
            FN_SUB:  alu = ALU_SUB;
            FN_AND:  alu = ALU_AND;
            FN_OR:   alu = ALU_OR;
            FN_SLT:  alu = ALU_SLT;
            default: fn_ok = 1'b0;
        endcase
    end

    // Explicit no-op is checked first so it never flags illegal.
    always_comb begin
        exe     = '0;
        mem     = '0;
        wb      = '0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_load = 1'b0;
        is_jump = 1'b0;
        illegal = 1'b0;
        if (opcode != NOP_OPCODE) begin
            case (opcode)
                OP_LOAD: begin
                    exe     = {1'b0, 1'b1, ALU_ADD};
                    mem     = 2'b10;
                    wb      = 2'b10;
                    is_load = 1'b1;
                end
                OP_STORE: begin
                    exe = {1'b0, 1'b1, ALU_ADD};
                    mem = 2'b01;
                end
                OP_RTYPE: begin
                    if (fn_ok) begin
                        exe = {1'b1, 1'b0, alu};
                        wb  = 2'b11;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OP_BEQ:  is_beq  = 1'b1;
                OP_BNE:  is_bne  = 1'b1;
                OP_JUMP: is_jump = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers, branch/jump redirect and kill FSM.
// Optional load-use stall detection is built when PIPE_CTRL_LOAD_USE_STALL_EN is defined.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned REG_W       = 5,
    parameter logic [5:0]  NOP_OPCODE  = 6'b111111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       opcode,
    input  logic [5:0]       Function,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             zero,
    output logic [4:0]       excutionSignals,
    output logic [1:0]       memorySignals,
    output logic [1:0]       writeBack,
    output logic [1:0]       pcSrc,
    output logic             flush,
    output logic             stall,
    output logic             illegal
);

    localparam int unsigned CNT_W = 2;

    logic [4:0]   dec_exe;
    logic [1:0]   dec_mem;
    logic [1:0]   dec_wb;
    logic         dec_beq, dec_bne, dec_load, dec_jump, dec_illegal;
    ctrl_bundle_t dec_bundle;

    state_t       state;
    logic [CNT_W-1:0] kill_cnt;
    ctrl_bundle_t idex_bundle;
    logic         idex_beq, idex_bne;
    logic [1:0]   exmem_mem, exmem_wb, memwb_wb;
    logic         illegal_q;

    logic         taken, in_kill, load_use, insert_bubble;

    ctrl_decoder #(.NOP_OPCODE(NOP_OPCODE)) u_dec (
        .opcode  (opcode),
        .funct   (Function),
        .exe     (dec_exe),
        .mem     (dec_mem),
        .wb      (dec_wb),
        .is_beq  (dec_beq),
        .is_bne  (dec_bne),
        .is_load (dec_load),
        .is_jump (dec_jump),
        .illegal (dec_illegal)
    );

    assign dec_bundle = id_valid ? ctrl_bundle_t'({dec_exe, dec_mem, dec_wb}) : BUBBLE;
    assign taken      = (idex_beq & zero) | (idex_bne & ~zero);
    assign in_kill    = (state == ST_KILL);

`ifdef PIPE_CTRL_LOAD_USE_STALL_EN
    logic             idex_load;
    logic [REG_W-1:0] idex_rt;

    // A load/jump in ID does not read rt, so only rs can conflict for those.
    assign load_use = idex_load && (idex_rt != '0) && id_valid && !in_kill &&
                      ((id_rs == idex_rt) || ((id_rt == idex_rt) && !dec_load && !dec_jump));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_load <= 1'b0;
            idex_rt   <= '0;
        end else begin
            idex_load <= ~insert_bubble & id_valid & dec_load;
            idex_rt   <= id_rt;
        end
    end
`else
    logic unused_ids;
    assign load_use   = 1'b0;
    assign unused_ids = ^{id_rs, id_rt, dec_load};
`endif

    assign insert_bubble = taken | in_kill | load_use;

    // Redirect/flush/stall, highest priority first.
    always_comb begin
        pcSrc = 2'b00;
        flush = 1'b0;
        stall = 1'b0;
        if (!rst) begin
            if (taken) begin
                pcSrc = 2'b01;
                flush = 1'b1;
            end else if (in_kill) begin
                flush = 1'b1;
            end else if (load_use) begin
                stall = 1'b1;
            end else if (id_valid && dec_jump) begin
                pcSrc = 2'b10;
                flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            kill_cnt    <= '0;
            idex_bundle <= BUBBLE;
            idex_beq    <= 1'b0;
            idex_bne    <= 1'b0;
            exmem_mem   <= '0;
            exmem_wb    <= '0;
            memwb_wb    <= '0;
            illegal_q   <= 1'b0;
        end else begin
            idex_bundle <= insert_bubble ? BUBBLE : dec_bundle;
            idex_beq    <= ~insert_bubble & id_valid & dec_beq;
            idex_bne    <= ~insert_bubble & id_valid & dec_bne;
            exmem_mem   <= idex_bundle.mem;
            exmem_wb    <= idex_bundle.wb;
            memwb_wb    <= exmem_wb;
            illegal_q   <= ~insert_bubble & id_valid & dec_illegal;

            // A taken branch always (re)loads the kill counter.
            if (taken) begin
                if (FLUSH_DEPTH > 1) begin
                    state    <= ST_KILL;
                    kill_cnt <= CNT_W'(FLUSH_DEPTH - 1);
                end else begin
                    state    <= ST_RUN;
                    kill_cnt <= '0;
                end
            end else begin
                case (state)
                    ST_KILL: begin
                        if (kill_cnt <= CNT_W'(1)) begin
                            state    <= ST_RUN;
                            kill_cnt <= '0;
                        end else begin
                            kill_cnt <= kill_cnt - CNT_W'(1);
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

    assign excutionSignals = idex_bundle.exe;
    assign memorySignals   = exmem_mem;
    assign writeBack       = memwb_wb;
    assign illegal         = illegal_q;

endmodule
